// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle Moore controller for the byte-wide 8-bit MIPS datapath
module mips_mc_controller #(
   parameter int IBYTES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        op,
   input  logic              zero,
   input  logic              memready,
   output logic              memwrite,
   output logic              iord,
   output logic [IBYTES-1:0] irwrite,
   output logic              alusrca,
   output logic [1:0]        alusrcb,
   output logic [1:0]        aluop,
   output logic [1:0]        pcsrc,
   output logic              pcen,
   output logic              regwrite,
   output logic              regdst,
   output logic              memtoreg,
   output logic [3:0]        state
);
   typedef enum logic [3:0] {
      FETCH1 = 4'd0, FETCH2 = 4'd1, FETCH3 = 4'd2, FETCH4 = 4'd3,
      DECODE = 4'd4, MEMADR = 4'd5, LBRD = 4'd6, LBWR = 4'd7, SBWR = 4'd8,
      RTYPEEX = 4'd9, RTYPEWR = 4'd10, BEQEX = 4'd11, JEX = 4'd12,
      ADDIEX = 4'd13, ADDIWR = 4'd14
   } state_t;
   typedef struct packed {
      logic              memwrite;
      logic              iord;
      logic [IBYTES-1:0] irwrite;
      logic              alusrca;
      logic [1:0]        alusrcb;
      logic [1:0]        aluop;
      logic [1:0]        pcsrc;
      logic              pcwrite;
      logic              branch;
      logic              regwrite;
      logic              regdst;
      logic              memtoreg;
      logic              waits;
   } ctl_t;
   localparam logic [5:0] OP_LB = 6'b100000, OP_SB = 6'b101000, OP_R = 6'b000000;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
   localparam logic [3:0] NF = 4'(IBYTES);
   localparam logic [3:0] LAST = 4'(IBYTES - 1);
   state_t cur, nxt;
   ctl_t ctl, g;
   // Control word of each state; waits marks steps that stall on memready
   function automatic ctl_t decode(state_t s);
      ctl_t c;
      c = '0;
      if (s < NF) begin
         c.irwrite = IBYTES'(1) << s;
         c.alusrcb = 2'b01;
         c.pcwrite = 1'b1;
         c.waits = 1'b1;
      end
      case (s)
         DECODE:  c.alusrcb = 2'b11;
         MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         LBRD:    begin c.iord = 1'b1; c.waits = 1'b1; end
         LBWR:    begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
         SBWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; c.waits = 1'b1; end
         RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
         RTYPEWR: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
         BEQEX:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.branch = 1'b1; c.pcsrc = 2'b01; end
         JEX:     begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
         ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         ADDIWR:  c.regwrite = 1'b1;
         default: ;
      endcase
      return c;
   endfunction
   // Next-state selection; illegal opcodes and unused codes fall back to FETCH1
   always_comb begin
      nxt = FETCH1;
      case (cur)
         DECODE:  nxt = (op == OP_LB || op == OP_SB) ? MEMADR :
                        op == OP_R ? RTYPEEX : op == OP_BEQ ? BEQEX :
                        op == OP_J ? JEX : op == OP_ADDI ? ADDIEX : FETCH1;
         MEMADR:  nxt = op == OP_LB ? LBRD : SBWR;
         LBRD:    nxt = memready ? LBWR : LBRD;
         SBWR:    nxt = memready ? FETCH1 : SBWR;
         RTYPEEX: nxt = RTYPEWR;
         ADDIEX:  nxt = ADDIWR;
         default: if (cur < NF) nxt = !memready ? cur : cur == LAST ? DECODE : state_t'(cur + 4'd1);
      endcase
   end
   // State and control word registered together so outputs are glitch-free
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur <= FETCH1;
         ctl <= decode(FETCH1);
      end else begin
         cur <= nxt;
         ctl <= decode(nxt);
      end
   end
   assign g = reset ? ctl : '0;
   assign memwrite = g.memwrite;
   assign iord = g.iord;
   assign irwrite = g.irwrite;
   assign alusrca = g.alusrca;
   assign alusrcb = g.alusrcb;
   assign aluop = g.aluop;
   assign pcsrc = g.pcsrc;
   assign regwrite = g.regwrite;
   assign regdst = g.regdst;
   assign memtoreg = g.memtoreg;
   assign pcen = (g.pcwrite & (memready | ~g.waits)) | (g.branch & zero);
   assign state = cur;
endmodule
